mem_bus_bridge: RTL and testbench

- Parametrised data-memory subsystem for the next CPU generation; replaces the direct processor-to-RAM hookup.
- Accepts one processor load/store at a time over a req/ready/done handshake with configurable wait states.
- Decodes each address to an internal RAM region or to N memory-mapped I/O channels, each with an output register and a synchronised input.
- Sits between processor data port and board I/O at CPU top level.

---
 rtl/mem_bus_bridge_if.sv | 24 ++
 rtl/mem_bus_bridge.sv | 147 ++++++++++++++
 tb/tb_mem_bus_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_bridge_if.sv
// Processor-side load/store handshake between a CPU data port and mem_bus_bridge.
interface mem_bus_bridge_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// Single-outstanding load/store bridge: the top address bit picks internal RAM or I/O channels,
// and the access takes effect on the accept edge, with done following after WAIT idle cycles.
module mem_bus_bridge #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned N_IO      = 4,
  parameter int unsigned WAIT      = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic                   clock,
  input  logic                   reset,
  mem_bus_bridge_if.slave        bus,
  output logic [N_IO*DATA_W-1:0] io_out,
  input  logic [N_IO*DATA_W-1:0] io_in
);

  localparam int unsigned RAM_AW    = ADDR_W - 1;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned IDX_W     = (N_IO > 1) ? $clog2(N_IO) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            r_state;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic              r_bad;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_io_out [N_IO];
  logic [DATA_W-1:0] r_sync1  [N_IO];
  logic [DATA_W-1:0] r_sync2  [N_IO];
  logic [DATA_W-1:0] r_mem    [RAM_DEPTH];

  logic              w_accept;
  logic              w_is_io;
  logic              w_io_hit;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [IDX_W-1:0]  w_io_sel;
  logic [DATA_W-1:0] w_load_data;

  assign w_accept   = bus.req && (r_state == StIdle);
  assign w_is_io    = bus.addr[ADDR_W-1];
  assign w_ram_addr = bus.addr[RAM_AW-1:0];
  assign w_io_sel   = bus.addr[IDX_W-1:0];
  assign w_io_hit   = w_is_io && (32'(bus.addr[RAM_AW-1:0]) < N_IO);

  always_comb begin
    w_load_data = '0;
    if (!w_is_io) begin
      w_load_data = r_mem[w_ram_addr];
    end else if (w_io_hit) begin
      w_load_data = r_sync2[w_io_sel];
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_accept && bus.we && !w_is_io) begin
      r_mem[w_ram_addr] <= bus.wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_IO; k++) begin
        r_sync1[k] <= '0;
        r_sync2[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_IO; k++) begin
        r_sync1[k] <= io_in[k*DATA_W +: DATA_W];
        r_sync2[k] <= r_sync1[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_bad   <= 1'b0;
      r_rdata <= '0;
      for (int k = 0; k < N_IO; k++) begin
        r_io_out[k] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.req) begin
            r_bad   <= w_is_io && !w_io_hit;
            r_ready <= 1'b0;
            if (bus.we) begin
              if (w_io_hit) begin
                r_io_out[w_io_sel] <= bus.wdata;
              end
            end else begin
              r_rdata <= w_load_data;
            end
            if (WAIT > 0) begin
              r_state <= StWait;
              r_cnt   <= 4'(WAIT);
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_err   <= w_is_io && !w_io_hit;
            end
          end
        end
        StWait: begin
          if (r_cnt == 4'd1) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_err   <= r_bad;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < N_IO; k++) begin : g_io_out
    assign io_out[k*DATA_W +: DATA_W] = r_io_out[k];
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: a vector table on a WAIT=0 instance plus hand sequences
// for wait-state timing (WAIT=3) and mid-transaction reset (WAIT=2).
module tb_mem_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  mem_bus_bridge_if #(.DATA_W(32), .ADDR_W(12)) a_if ();
  mem_bus_bridge_if #(.DATA_W(32), .ADDR_W(12)) b_if ();
  mem_bus_bridge_if #(.DATA_W(32), .ADDR_W(12)) c_if ();

  logic [127:0] a_io_out, a_io_in, b_io_out, b_io_in, c_io_out, c_io_in;

  mem_bus_bridge #(.DATA_W(32), .ADDR_W(12), .N_IO(4), .WAIT(0)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (a_if),
    .io_out(a_io_out),
    .io_in (a_io_in)
  );

  mem_bus_bridge #(.DATA_W(32), .ADDR_W(12), .N_IO(4), .WAIT(3)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (b_if),
    .io_out(b_io_out),
    .io_in (b_io_in)
  );

  mem_bus_bridge #(.DATA_W(32), .ADDR_W(12), .N_IO(4), .WAIT(2)) dut_c (
    .clock (clk),
    .reset (rst_c),
    .bus   (c_if),
    .io_out(c_io_out),
    .io_in (c_io_in)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic txn_a(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("a_ready_at_req", a_if.ready, 1'b1);
    a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
    @(negedge clk);
    a_if.req = 1'b0;
    lat = 0;
    while (!a_if.done && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rd = a_if.rdata;
    er = a_if.err;
  endtask

  task automatic txn_c(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
    @(negedge clk);
    c_if.req = 1'b1; c_if.we = we; c_if.addr = addr; c_if.wdata = wd;
    @(negedge clk);
    c_if.req = 1'b0;
    lat = 0;
    while (!c_if.done && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rd = c_if.rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          dcnt;

    vecs[0]  = '{1'b1, 12'h005, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 12'h005, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 12'h010, 32'h11111111, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 12'h011, 32'h22222222, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 12'h012, 32'h33333333, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 12'h013, 32'h44444444, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 12'h010, 32'h00000000, 32'h11111111, 1'b0};
    vecs[7]  = '{1'b0, 12'h011, 32'h00000000, 32'h22222222, 1'b0};
    vecs[8]  = '{1'b0, 12'h012, 32'h00000000, 32'h33333333, 1'b0};
    vecs[9]  = '{1'b0, 12'h013, 32'h00000000, 32'h44444444, 1'b0};
    vecs[10] = '{1'b1, 12'h802, 32'hA5A5A5A5, 32'h44444444, 1'b0};
    vecs[11] = '{1'b1, 12'h804, 32'hFFFFFFFF, 32'h44444444, 1'b1};
    vecs[12] = '{1'b0, 12'h9FF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[13] = '{1'b0, 12'h802, 32'h00000000, 32'h00000000, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    a_io_in = '0; b_io_in = '0; c_io_in = '0;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
    c_if.req = 1'b0; c_if.we = 1'b0; c_if.addr = '0; c_if.wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", a_if.ready, 1'b1);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_rdata", a_if.rdata, 32'h0);
    chk("rst_err", a_if.err, 1'b0);
    chk("rst_io_out", a_io_out, 128'h0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Vector table on the WAIT=0 instance; each request issues the cycle ready returns.
    for (int i = 0; i < 14; i++) begin
      txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("a_vec%0d_latency", i), lat, 0);
      chk($sformatf("a_vec%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("a_vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    chk("a_io_out_after_stores", a_io_out, 128'h00000000_A5A5A5A5_00000000_00000000);

    // Input synchroniser: a load on the very edge after the change still sees the old value.
    @(negedge clk);
    a_io_in[32 +: 32] = 32'h00000042;
    repeat (2) @(posedge clk);
    txn_a(1'b0, 12'h801, 32'h0, rd, er, lat);
    chk("a_io_ch1_rdata", rd, 32'h00000042);
    chk("a_io_ch1_err", er, 1'b0);

    @(negedge clk);
    a_io_in[96 +: 32] = 32'h00000077;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 12'h803;
    @(negedge clk);
    a_if.req = 1'b0;
    chk("a_io_early_done", a_if.done, 1'b1);
    chk("a_io_early_rdata", a_if.rdata, 32'h0);
    txn_a(1'b0, 12'h803, 32'h0, rd, er, lat);
    chk("a_io_ch3_rdata", rd, 32'h00000077);

    // WAIT=3: store, then a load whose req stays high through the busy window.
    @(negedge clk);
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 12'h7FF; b_if.wdata = 32'h12345678;
    @(negedge clk);
    b_if.req = 1'b0;
    n = 0;
    while (!b_if.done && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("b_store_latency", n, 3);
    @(negedge clk);
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 12'h7FF;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk($sformatf("b_ready_cyc%0d", j), b_if.ready, (j == 5));
      chk($sformatf("b_done_cyc%0d", j), b_if.done, (j == 4));
      if (j == 4) chk("b_load_rdata", b_if.rdata, 32'h12345678);
    end
    b_if.req = 1'b0;
    n = 0;
    while (!b_if.done && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("b_held_req_latency", n, 3);
    chk("b_held_req_rdata", b_if.rdata, 32'h12345678);

    // WAIT=2: reset in the wait window aborts the load but keeps RAM.
    txn_c(1'b1, 12'h020, 32'hCAFEF00D, rd, lat);
    chk("c_store_latency", lat, 2);
    txn_c(1'b1, 12'h800, 32'h00000011, rd, lat);
    chk("c_io_out_before_reset", c_io_out, 128'h11);
    @(negedge clk);
    c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 12'h020;
    @(negedge clk);
    c_if.req = 1'b0;
    chk("c_busy_before_reset", c_if.ready, 1'b0);
    #2 rst_c = 1'b0;
    #1;
    chk("c_reset_ready", c_if.ready, 1'b1);
    chk("c_reset_done", c_if.done, 1'b0);
    chk("c_reset_rdata", c_if.rdata, 32'h0);
    chk("c_reset_io_out", c_io_out, 128'h0);
    @(negedge clk);
    rst_c = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (c_if.done) dcnt++;
    end
    chk("c_no_done_after_reset", dcnt, 0);
    txn_c(1'b0, 12'h020, 32'h0, rd, lat);
    chk("c_ram_kept_latency", lat, 2);
    chk("c_ram_kept_rdata", rd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
